// File: rtl/apu_slew_pkg.sv
// apu_slew_pkg: shared FSM state type and field widths for the APU slew scheduler
package apu_slew_pkg;
  localparam int SPEED_W = 16;
  localparam int DIV_W = 16;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_e;
endpackage

// File: rtl/apu_slew_step.sv
// apu_slew_step: combinational slew step for one channel, shared across the sweep
module apu_slew_step import apu_slew_pkg::*; #(
  parameter int SIGNAL_WIDTH = 16
) (
  input  logic signed [SIGNAL_WIDTH-1:0] cur_i,
  input  logic signed [SIGNAL_WIDTH-1:0] target_i,
  input  logic signed [SPEED_W-1:0]      speed_i,
  input  logic        [DIV_W-1:0]        div_i,
  output logic signed [SIGNAL_WIDTH-1:0] cur_o,
  output logic        [DIV_W-1:0]        div_o
);
  // wide enough for the signed delta and for -(-32768) as a positive divisor
  localparam int CW = SIGNAL_WIDTH + 1 > SPEED_W + 1 ? SIGNAL_WIDTH + 1 : SPEED_W + 1;
  logic signed [CW-1:0] cur_x, tgt_x, spd_x, delta, mag, n, stepped;
  logic up, zero, neg, pos, reach, fire;
  always_comb begin
    cur_x = CW'(cur_i);
    tgt_x = CW'(target_i);
    spd_x = CW'(speed_i);
    delta = tgt_x - cur_x;
    up = !delta[CW-1];
    mag = up ? delta : -delta;
    n = -spd_x;
    zero = speed_i == '0;
    neg = speed_i[SPEED_W-1];
    pos = !neg && !zero;
    reach = mag <= spd_x;
    fire = {{(CW-DIV_W){1'b0}}, div_i} == n - CW'(1);
    stepped = cur_x + (up ? spd_x : -spd_x);
    div_o = neg ? (fire ? '0 : div_i + DIV_W'(1)) : div_i;
    cur_o = zero || (pos && reach) ? target_i
          : pos ? stepped[SIGNAL_WIDTH-1:0]
          : neg && fire && delta != '0 ? (up ? cur_i + SIGNAL_WIDTH'(1) : cur_i - SIGNAL_WIDTH'(1))
          : cur_i;
  end
endmodule

// File: rtl/apu_slew_scheduler.sv
// apu_slew_scheduler: per-channel slew controller, one channel stepped per cycle on each sample tick
module apu_slew_scheduler import apu_slew_pkg::*; #(
  parameter int CHANNELS = 4,
  parameter int SIGNAL_WIDTH = 16,
  localparam int IW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             sample_tick,
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  input  logic [IW-1:0]                    cfg_channel,
  input  logic [SIGNAL_WIDTH-1:0]          cfg_target,
  input  logic [SPEED_W-1:0]               cfg_speed,
  output logic [CHANNELS*SIGNAL_WIDTH-1:0] o_signal,
  output logic                             busy,
  output logic                             sweep_done,
  output logic                             overrun
);
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic overrun_q, cfg_fire;
  logic signed [SIGNAL_WIDTH-1:0] cur_q [CHANNELS];
  logic signed [SIGNAL_WIDTH-1:0] target_q [CHANNELS];
  logic signed [SPEED_W-1:0] speed_q [CHANNELS];
  logic [DIV_W-1:0] div_q [CHANNELS];
  logic signed [SIGNAL_WIDTH-1:0] step_cur;
  logic [DIV_W-1:0] step_div;
  always_ff @(posedge clk)
    if (!rstn) begin
      state_q <= IDLE;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
    end
  always_comb begin
    state_d = state_q == IDLE ? (sample_tick ? SWEEP : IDLE)
            : state_q == SWEEP ? (32'(idx_q) == CHANNELS - 1 ? DONE : SWEEP)
            : IDLE;
    idx_d = state_q == SWEEP ? idx_q + IW'(1) : '0;
  end
  always_comb begin
    busy = state_q != IDLE;
    sweep_done = state_q == DONE;
    cfg_ready = state_q != SWEEP;
    overrun = overrun_q;
  end
  always_comb
    for (int k = 0; k < CHANNELS; k++) o_signal[k*SIGNAL_WIDTH +: SIGNAL_WIDTH] = cur_q[k];
  // out-of-range channels complete the handshake but write nothing
  assign cfg_fire = cfg_valid && cfg_ready && 32'(cfg_channel) < CHANNELS;
  apu_slew_step #(.SIGNAL_WIDTH(SIGNAL_WIDTH)) u_step (
    .cur_i    (cur_q[idx_q]),
    .target_i (target_q[idx_q]),
    .speed_i  (speed_q[idx_q]),
    .div_i    (div_q[idx_q]),
    .cur_o    (step_cur),
    .div_o    (step_div)
  );
  always_ff @(posedge clk)
    if (!rstn) begin
      overrun_q <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        cur_q[k] <= '0;
        target_q[k] <= '0;
        speed_q[k] <= '0;
        div_q[k] <= '0;
      end
    end else begin
      overrun_q <= sample_tick && state_q != IDLE;
      if (cfg_fire) begin
        target_q[cfg_channel] <= cfg_target;
        speed_q[cfg_channel] <= cfg_speed;
        div_q[cfg_channel] <= '0;
      end
      if (state_q == SWEEP) begin
        cur_q[idx_q] <= step_cur;
        div_q[idx_q] <= step_div;
      end
    end
endmodule
